// File: rtl/gpr_pkg.sv
// ----------------------------------------------------------------------------
// gpr_pkg : shared widths, requester indices and write-request type for the
//           GPR write-back path.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gpr_pkg;

   localparam int GPR_AW  = 5;
   localparam int GPR_DW  = 32;
   localparam int NUM_REQ = 3;

   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;
   localparam int REQ_MDU = 2;

   typedef struct packed {
      logic [GPR_AW-1:0] dst;
      logic [GPR_DW-1:0] data;
   } wb_req_t;

   // One-hot register mask used by the decode hazard logic
   function automatic logic [31:0] reg_onehot(input logic [GPR_AW-1:0] r);
      return 32'd1 << r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_prio_sel.sv
// ----------------------------------------------------------------------------
// wb_prio_sel : combinational write-back grant select. Promoted (aged)
//               requesters win first, lowest index among them; otherwise
//               fixed priority ALU > LSU > MDU.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_prio_sel
   import gpr_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic [NUM_REQ-1:0] promoted,
   output logic [NUM_REQ-1:0] grant
);

   logic [NUM_REQ-1:0] aged;

   always_comb begin
      grant = '0;
      // A stale promotion flag must never grant a withdrawn request
      aged  = valid & promoted;
      if (aged[REQ_ALU])
         grant[REQ_ALU] = 1'b1;
      else if (aged[REQ_LSU])
         grant[REQ_LSU] = 1'b1;
      else if (aged[REQ_MDU])
         grant[REQ_MDU] = 1'b1;
      else if (valid[REQ_ALU])
         grant[REQ_ALU] = 1'b1;
      else if (valid[REQ_LSU])
         grant[REQ_LSU] = 1'b1;
      else if (valid[REQ_MDU])
         grant[REQ_MDU] = 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
// ----------------------------------------------------------------------------
// gpr_wb_arbiter : shares the GPR write port between ALU, LSU and MDU and
//                  publishes the pending-write mask. Define WB_AGING_EN to
//                  enable starvation-avoiding age promotion.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gpr_wb_arbiter
   import gpr_pkg::*;
#(
   parameter int AW        = GPR_AW,
   parameter int DW        = GPR_DW,
   parameter int AGE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [AW-1:0]        req_reg0,
   input  logic [AW-1:0]        req_reg1,
   input  logic [AW-1:0]        req_reg2,
   input  logic [DW-1:0]        req_data0,
   input  logic [DW-1:0]        req_data1,
   input  logic [DW-1:0]        req_data2,
   output logic                 gpr_wen,
   output logic [AW-1:0]        gpr_wreg,
   output logic [DW-1:0]        gpr_wdata,
   output logic [31:0]          pend_mask,
   output logic                 busy
);

   // An out-of-range limit fails elaboration on the missing module
   generate
      if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_age_limit_illegal
         age_limit_out_of_range u_bad_age_limit ();
      end
   endgenerate

   logic [NUM_REQ-1:0] promoted;
   logic [NUM_REQ-1:0] grant;
   logic [AW-1:0]      sel_reg;
   logic [DW-1:0]      sel_data;
   logic               accept;
   logic               wen_q;
   logic [AW-1:0]      wreg_q;
   logic [DW-1:0]      wdata_q;

   wb_prio_sel u_prio_sel (
      .valid    (req_valid),
      .promoted (promoted),
      .grant    (grant)
   );

   always_comb begin
      req_ready = rst ? '0 : grant;
      busy      = |(req_valid & ~req_ready);
      accept    = |req_ready;
   end

   always_comb begin
      sel_reg  = '0;
      sel_data = '0;
      if (req_ready[REQ_ALU]) begin
         sel_reg  = req_reg0;
         sel_data = req_data0;
      end else if (req_ready[REQ_LSU]) begin
         sel_reg  = req_reg1;
         sel_data = req_data1;
      end else if (req_ready[REQ_MDU]) begin
         sel_reg  = req_reg2;
         sel_data = req_data2;
      end
   end

   // Write stage drains every cycle; r0 writes are accepted but never enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wen_q   <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
      end else begin
         wen_q <= accept && (sel_reg != '0);
         if (accept) begin
            wreg_q  <= sel_reg;
            wdata_q <= sel_data;
         end
      end
   end

   assign gpr_wen   = wen_q;
   assign gpr_wreg  = wreg_q;
   assign gpr_wdata = wdata_q;
   assign pend_mask = wen_q ? reg_onehot(wreg_q) : 32'd0;

`ifdef WB_AGING_EN
   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
         logic [3:0] wait_cnt;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               wait_cnt <= 4'd0;
            else if (!req_valid[i] || req_ready[i])
               wait_cnt <= 4'd0;
            else if (wait_cnt != 4'(AGE_LIMIT))
               wait_cnt <= wait_cnt + 4'd1;
         end

         assign promoted[i] = (wait_cnt == 4'(AGE_LIMIT));
      end
   endgenerate
`else
   assign promoted = '0;
`endif

endmodule

`default_nettype wire
